// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches ahead of the fetch stage,
// buffers in-order responses with their PCs, and flushes/retargets on jmp_vld.
// Optional PF_STAT_EN adds starvation and flush event counters.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvld,
    input  logic [31:0] mem_rdata,
    input  logic        jmp_vld,
    input  logic [31:0] jmp_addr,
    input  logic        pf_rdy,
    output logic        pf_vld,
    output logic [31:0] pf_pc,
    output logic [31:0] pf_inst
`ifdef PF_STAT_EN
    ,
    output logic [31:0] pf_starve_cnt,
    output logic [31:0] pf_flush_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outs;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   inst_q [DEPTH];

    logic          issue;
    logic          pop;
    logic          wr_en;
    logic [CW:0]   used;

    // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
    always_comb begin
        used     = {1'b0, count} + {1'b0, outs};
        mem_req  = rst && !jmp_vld && (used < (CW+1)'(DEPTH));
        mem_addr = fetch_pc;
        issue    = mem_req && mem_gnt;
        pf_vld   = (count != '0);
        pop      = pf_vld && pf_rdy && !jmp_vld;
        wr_en    = mem_rvld && !jmp_vld && (drop == '0);
    end

    always_comb begin
        pf_pc   = 32'h0000_0000;
        pf_inst = NOP;
        if (pf_vld) begin
            pf_pc   = pc_q[rd_ptr];
            pf_inst = inst_q[rd_ptr];
        end
    end

    // A flush takes priority over issue, write and pop; responses already on the
    // bus are counted into drop so they are discarded when they arrive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outs     <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (jmp_vld) begin
            fetch_pc <= jmp_addr;
            resp_pc  <= jmp_addr;
            outs     <= outs - CW'(mem_rvld);
            drop     <= outs - CW'(mem_rvld);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outs <= outs + CW'(issue) - CW'(mem_rvld);
            if (mem_rvld && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            if (wr_en) begin
                wr_ptr  <= wr_ptr + AW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_q[wr_ptr]   <= resp_pc;
            inst_q[wr_ptr] <= mem_rdata;
        end
    end

`ifdef PF_STAT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            pf_starve_cnt <= '0;
            pf_flush_cnt  <= '0;
        end else begin
            if (pf_rdy && !pf_vld && !jmp_vld) begin
                pf_starve_cnt <= pf_starve_cnt + 32'd1;
            end
            if (jmp_vld) begin
                pf_flush_cnt <= pf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with a simple in-order memory responder.
// Build with PF_STAT_EN defined to also exercise the statistics counters.
module tb_inst_prefetch_queue;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvld;
    logic [31:0] mem_rdata;
    logic        jmp_vld;
    logic [31:0] jmp_addr;
    logic        pf_rdy;
    logic        pf_vld;
    logic [31:0] pf_pc;
    logic [31:0] pf_inst;
`ifdef PF_STAT_EN
    logic [31:0] pf_starve_cnt;
    logic [31:0] pf_flush_cnt;
`endif

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_gnt  (mem_gnt),
        .mem_rvld (mem_rvld),
        .mem_rdata(mem_rdata),
        .jmp_vld  (jmp_vld),
        .jmp_addr (jmp_addr),
        .pf_rdy   (pf_rdy),
        .pf_vld   (pf_vld),
        .pf_pc    (pf_pc),
        .pf_inst  (pf_inst)
`ifdef PF_STAT_EN
        ,
        .pf_starve_cnt(pf_starve_cnt),
        .pf_flush_cnt (pf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          cyc;
    int          lat;
    int          n_issue;
    logic        gnt_on;
    logic [31:0] q_addr[$];
    int          q_due[$];

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_vld;
    logic [31:0] obs_pc;
    logic [31:0] obs_inst;
    logic        found;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0001) ^ 32'h0000_0513;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at the negedge: drive the bus for this cycle, sample outputs, then clock.
    task automatic applyStimulus();
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            mem_rvld  = 1'b1;
            mem_rdata = mem_word(q_addr[0]);
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
        end else begin
            mem_rvld  = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
        end
        mem_gnt = gnt_on;
        #1;
        obs_req  = mem_req;
        obs_addr = mem_addr;
        obs_vld  = pf_vld;
        obs_pc   = pf_pc;
        obs_inst = pf_inst;
        if (mem_req && mem_gnt) begin
            q_addr.push_back(mem_addr);
            q_due.push_back(cyc + lat);
            n_issue++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic applyReset(input int latency);
        rst      = 1'b0;
        jmp_vld  = 1'b0;
        jmp_addr = 32'h0;
        pf_rdy   = 1'b1;
        gnt_on   = 1'b1;
        lat      = latency;
        q_addr.delete();
        q_due.delete();
        applyStimulus();
        applyStimulus();
        rst     = 1'b1;
        cyc     = 0;
        n_issue = 0;
    endtask

    task automatic waitValid();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus();
            if (obs_vld) found = 1'b1;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        n_issue   = 0;
        lat       = 1;
        gnt_on    = 1'b1;
        rst       = 1'b0;
        mem_gnt   = 1'b0;
        mem_rvld  = 1'b0;
        mem_rdata = 32'h0;
        jmp_vld   = 1'b0;
        jmp_addr  = 32'h0;
        pf_rdy    = 1'b0;
        @(negedge clk);

        // Reset state
        applyReset(1);
        checkOutput("rst_req",  {31'b0, obs_req}, 32'd0);
        checkOutput("rst_addr", obs_addr, 32'h0);
        checkOutput("rst_vld",  {31'b0, obs_vld}, 32'd0);
        checkOutput("rst_pc",   obs_pc, 32'h0);
        checkOutput("rst_inst", obs_inst, 32'h0000_0013);

        // Streaming at one instruction per cycle with 1-cycle latency
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
            checkOutput("s_req",  {31'b0, obs_req}, 32'd1);
            checkOutput("s_addr", obs_addr, 32'(4 * k));
            if (k >= 2) begin
                checkOutput("s_vld",  {31'b0, obs_vld}, 32'd1);
                checkOutput("s_pc",   obs_pc, 32'(4 * (k - 2)));
                checkOutput("s_inst", obs_inst, mem_word(32'(4 * (k - 2))));
            end
        end

        // Stall fills the queue to DEPTH, then drains in order
        applyReset(1);
        pf_rdy = 1'b0;
        for (int k = 0; k < 10; k++) applyStimulus();
        checkOutput("full_issues", 32'(n_issue), 32'd4);
        checkOutput("full_req",    {31'b0, obs_req}, 32'd0);
        checkOutput("full_vld",    {31'b0, obs_vld}, 32'd1);
        pf_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("drain_pc",   obs_pc, 32'(4 * k));
            checkOutput("drain_inst", obs_inst, mem_word(32'(4 * k)));
            if (k == 0) checkOutput("drain_req0", {31'b0, obs_req}, 32'd0);
            if (k == 1) begin
                checkOutput("drain_req1",  {31'b0, obs_req}, 32'd1);
                checkOutput("drain_addr1", obs_addr, 32'd16);
            end
        end

        // Three requests in flight when the redirect arrives
        applyReset(4);
        for (int k = 0; k < 3; k++) applyStimulus();
        jmp_vld  = 1'b1;
        jmp_addr = 32'h100;
        applyStimulus();
        checkOutput("j3_req_flush", {31'b0, obs_req}, 32'd0);
        jmp_vld = 1'b0;
        applyStimulus();
        checkOutput("j3_req",  {31'b0, obs_req}, 32'd1);
        checkOutput("j3_addr", obs_addr, 32'h100);
        waitValid();
        checkOutput("j3_found", {31'b0, found}, 32'd1);
        checkOutput("j3_pc",    obs_pc, 32'h100);
        checkOutput("j3_inst",  obs_inst, mem_word(32'h100));

        // Redirect coincident with a response and a pop
        applyReset(1);
        for (int k = 0; k < 3; k++) applyStimulus();
        jmp_vld  = 1'b1;
        jmp_addr = 32'h200;
        applyStimulus();
        checkOutput("jc_pop_vld", {31'b0, obs_vld}, 32'd1);
        checkOutput("jc_pop_pc",  obs_pc, 32'h4);
        jmp_vld = 1'b0;
        applyStimulus();
        checkOutput("jc_vld_a", {31'b0, obs_vld}, 32'd0);
        checkOutput("jc_addr",  obs_addr, 32'h200);
        applyStimulus();
        checkOutput("jc_vld_b", {31'b0, obs_vld}, 32'd0);
        applyStimulus();
        checkOutput("jc_vld_c", {31'b0, obs_vld}, 32'd1);
        checkOutput("jc_pc",    obs_pc, 32'h200);
        checkOutput("jc_inst",  obs_inst, mem_word(32'h200));

        // Back-to-back redirects: the second target wins
        applyReset(1);
        for (int k = 0; k < 3; k++) applyStimulus();
        jmp_vld  = 1'b1;
        jmp_addr = 32'h300;
        applyStimulus();
        jmp_addr = 32'h400;
        applyStimulus();
        checkOutput("bb_req", {31'b0, obs_req}, 32'd0);
        jmp_vld = 1'b0;
        applyStimulus();
        checkOutput("bb_addr", obs_addr, 32'h400);
        waitValid();
        checkOutput("bb_found", {31'b0, found}, 32'd1);
        checkOutput("bb_pc",    obs_pc, 32'h400);

        // Withheld grant holds the request stable
        applyReset(1);
        gnt_on = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("ng_req",  {31'b0, obs_req}, 32'd1);
            checkOutput("ng_addr", obs_addr, 32'h0);
        end
        gnt_on = 1'b1;
        applyStimulus();
        checkOutput("g_addr0", obs_addr, 32'h0);
        applyStimulus();
        checkOutput("g_req1",  {31'b0, obs_req}, 32'd1);
        checkOutput("g_addr1", obs_addr, 32'h4);

`ifdef PF_STAT_EN
        // Starved cycles with two flushes in between; flush cycles are not starved
        applyReset(1);
        gnt_on = 1'b0;
        for (int k = 0; k < 9; k++) begin
            jmp_vld  = (k == 2 || k == 5);
            jmp_addr = 32'h500;
            applyStimulus();
        end
        jmp_vld = 1'b0;
        checkOutput("stat_flush",  pf_flush_cnt, 32'd2);
        checkOutput("stat_starve", pf_starve_cnt, 32'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
